// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared widths, the FIFO entry layout and write-source encoding for the GPR writeback arbiter.
package gpr_wb_arbiter_pkg;

  localparam int REG_AW  = 5;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = REG_AW + DATA_W;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_A,
    SRC_B
  } wb_src_e;

  function automatic logic is_real_reg(input logic [REG_AW-1:0] r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// In-order buffer for long-latency results; show-ahead head so the arbiter can pop and
// forward the head entry in the same cycle.
module gpr_wb_fifo
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               empty,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Merges pipeline writeback (port A, priority) and buffered long-latency results (port B)
// onto the single GPR write port, tracking which registers still await a port-B result.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_we,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_wd,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_wd,
  output logic        b_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  output logic        q_rs_busy,
  output logic        q_rt_busy,
  output logic        a_stall,
  output logic        waw_err,
  output logic        gpr_we,
  output logic [4:0]  gpr_addr,
  output logic [31:0] gpr_wd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(STARVE_LIMIT);

  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_empty;
  logic [PTR_W:0]     fifo_count;
  wb_entry_t          head;
  wb_entry_t          b_entry;
  logic               a_eff;
  logic               push;
  logic               pop;
  wb_src_e            src;

  logic [31:0]        pending_reg, pending_next;
  logic [CNT_W-1:0]   starve_reg, starve_next;
  logic               a_stall_reg;
  logic               waw_reg, waw_next;
  logic               gpr_we_reg, gpr_we_next;
  logic [4:0]         gpr_addr_reg, gpr_addr_next;
  logic [31:0]        gpr_wd_reg, gpr_wd_next;

  assign a_eff   = a_we && is_real_reg(a_addr);
  assign b_ready = (fifo_count != FULL_CNT);
  assign push    = b_valid && b_ready;
  assign head    = wb_entry_t'(fifo_dout);
  assign b_entry = '{addr: b_addr, wd: b_wd};

  gpr_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (b_entry),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Port A always wins; port B drains only on cycles A leaves the write port free.
  always_comb begin
    src = SRC_NONE;
    if (a_eff) begin
      src = SRC_A;
    end else if (!fifo_empty) begin
      src = SRC_B;
    end
  end

  assign pop = (src == SRC_B);

  always_comb begin
    gpr_we_next   = 1'b0;
    gpr_addr_next = gpr_addr_reg;
    gpr_wd_next   = gpr_wd_reg;
    case (src)
      SRC_A: begin
        gpr_we_next   = 1'b1;
        gpr_addr_next = a_addr;
        gpr_wd_next   = a_wd;
      end
      SRC_B: begin
        // A result aimed at $0 still drains from the FIFO but never writes.
        if (is_real_reg(head.addr)) begin
          gpr_we_next   = 1'b1;
          gpr_addr_next = head.addr;
          gpr_wd_next   = head.wd;
        end
      end
      default: ;
    endcase
  end

  // Clear before set, so a same-cycle reservation of the register being drained survives.
  always_comb begin
    pending_next = pending_reg;
    if (pop) begin
      pending_next[head.addr] = 1'b0;
    end
    if (rsv_valid && is_real_reg(rsv_addr)) begin
      pending_next[rsv_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_comb begin
    starve_next = starve_reg;
    if (pop || fifo_empty) begin
      starve_next = '0;
    end else if (a_eff && starve_reg != LIMIT) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  assign waw_next = waw_reg | (a_eff && pending_reg[a_addr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg  <= '0;
      starve_reg   <= '0;
      a_stall_reg  <= 1'b0;
      waw_reg      <= 1'b0;
      gpr_we_reg   <= 1'b0;
      gpr_addr_reg <= '0;
      gpr_wd_reg   <= '0;
    end else begin
      pending_reg  <= pending_next;
      starve_reg   <= starve_next;
      a_stall_reg  <= (starve_next >= LIMIT);
      waw_reg      <= waw_next;
      gpr_we_reg   <= gpr_we_next;
      gpr_addr_reg <= gpr_addr_next;
      gpr_wd_reg   <= gpr_wd_next;
    end
  end

  assign q_rs_busy = pending_reg[q_rs];
  assign q_rt_busy = pending_reg[q_rt];
  assign a_stall   = a_stall_reg;
  assign waw_err   = waw_reg;
  assign gpr_we    = gpr_we_reg;
  assign gpr_addr  = gpr_addr_reg;
  assign gpr_wd    = gpr_wd_reg;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench: the driver steps a queue-based reference model and queues the expected
// gpr write for every clock edge; a separate monitor compares the gpr port against it.
module tb_gpr_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we, b_valid, rsv_valid;
  logic [4:0]  a_addr, b_addr, rsv_addr, q_rs, q_rt;
  logic [31:0] a_wd, b_wd;
  logic        b_ready, q_rs_busy, q_rt_busy, a_stall, waw_err, gpr_we;
  logic [4:0]  gpr_addr;
  logic [31:0] gpr_wd;

  gpr_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
    .b_valid(b_valid), .b_addr(b_addr), .b_wd(b_wd), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .q_rs(q_rs), .q_rt(q_rt), .q_rs_busy(q_rs_busy), .q_rt_busy(q_rt_busy),
    .a_stall(a_stall), .waw_err(waw_err),
    .gpr_we(gpr_we), .gpr_addr(gpr_addr), .gpr_wd(gpr_wd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        we;
    bit [4:0]  addr;
    bit [31:0] wd;
  } exp_t;

  exp_t      exp_q[$];
  bit [36:0] mdl_fifo[$];
  bit [31:0] mdl_pend;
  int        mdl_starve;
  bit        mdl_waw;
  int        errors = 0;
  int        checks = 0;
  int        txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mdl_fifo.delete();
    exp_q.delete();
    mdl_pend   = '0;
    mdl_starve = 0;
    mdl_waw    = 0;
  endtask

  task automatic set_idle();
    a_we = 0; a_addr = 0; a_wd = 0;
    b_valid = 0; b_addr = 0; b_wd = 0;
    rsv_valid = 0; rsv_addr = 0; q_rs = 0; q_rt = 0;
  endtask

  // One clock of stimulus: check the state left by the previous edge, then predict the next.
  task automatic cycle(input bit aw, input bit [4:0] aa, input bit [31:0] ad,
                       input bit bv, input bit [4:0] ba, input bit [31:0] bd,
                       input bit rv, input bit [4:0] ra, input bit [4:0] qs, input bit [4:0] qt);
    bit        a_eff, ready, popped, was_empty;
    bit [36:0] h;
    exp_t      e;
    @(negedge clk);
    a_we = aw; a_addr = aa; a_wd = ad;
    b_valid = bv; b_addr = ba; b_wd = bd;
    rsv_valid = rv; rsv_addr = ra; q_rs = qs; q_rt = qt;
    #1;
    check("b_ready",   b_ready,   mdl_fifo.size() < DEPTH);
    check("q_rs_busy", q_rs_busy, mdl_pend[qs]);
    check("q_rt_busy", q_rt_busy, mdl_pend[qt]);
    check("a_stall",   a_stall,   mdl_starve >= LIMIT);
    check("waw_err",   waw_err,   mdl_waw);

    a_eff     = aw && (aa != 0);
    ready     = mdl_fifo.size() < DEPTH;
    was_empty = mdl_fifo.size() == 0;
    popped    = 0;
    e         = '0;
    if (a_eff) begin
      e = '{we: 1'b1, addr: aa, wd: ad};
      if (mdl_pend[aa]) mdl_waw = 1;
    end else if (!was_empty) begin
      h      = mdl_fifo.pop_front();
      popped = 1;
      e      = '{we: (h[36:32] != 0), addr: h[36:32], wd: h[31:0]};
      mdl_pend[h[36:32]] = 0;
    end
    if (popped || was_empty)  mdl_starve = 0;
    else if (a_eff)           mdl_starve = (mdl_starve + 1 > LIMIT) ? LIMIT : mdl_starve + 1;
    if (bv && ready)          mdl_fifo.push_back({ba, bd});
    if (rv && ra != 0)        mdl_pend[ra] = 1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gpr_we"},   gpr_we,   0);
    check({tag, "_gpr_addr"}, gpr_addr, 0);
    check({tag, "_gpr_wd"},   gpr_wd,   0);
    check({tag, "_a_stall"},  a_stall,  0);
    check({tag, "_waw_err"},  waw_err,  0);
    check({tag, "_b_ready"},  b_ready,  1);
    check({tag, "_busy"},     q_rs_busy, 0);
  endtask

  // Monitor: one expected result per clock edge once stimulus is running.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (exp_q.size() == 0) begin
        if (gpr_we !== 1'b0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got we=%b addr=%0d wd=%0h expected none", gpr_we, gpr_addr, gpr_wd);
        end
      end else begin
        e = exp_q.pop_front();
        txn++;
        check("gpr_we", gpr_we, e.we);
        if (e.we) begin
          check("gpr_addr", gpr_addr, e.addr);
          check("gpr_wd",   gpr_wd,   e.wd);
        end
        $display("txn %0d: we=%b addr=%0d wd=%0h", txn, gpr_we, gpr_addr, gpr_wd);
      end
    end
  end

  initial begin : driver
    bit aw, bv, rv;
    set_idle();
    rst = 1;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 0;

    // A-only writes, including a $0 write that must be dropped.
    cycle(1, 5, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 32'h55,   0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // B path with reservation and busy query.
    cycle(0, 0, 0, 0, 0, 0, 1, 8, 8, 0);
    cycle(0, 0, 0, 1, 8, 32'h1234, 0, 0, 8, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 8, 0);

    // Collision: A first, B on the following cycle.
    cycle(1, 3, 32'hAA, 1, 9, 32'hBB, 0, 0, 0, 0);
    idle(2);

    // Fill the FIFO under continuous A traffic, then starve port B until a_stall.
    for (int i = 0; i < 12; i++)
      cycle(1, 5'(1 + i), 32'hA000 + i, (i < 5), 5'(16 + i), 32'hB000 + i, 0, 0, 0, 0);
    idle(6);

    // WAW hazard and same-cycle reserve/clear of one register.
    cycle(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    cycle(1, 4, 32'h44, 0, 0, 0, 0, 0, 4, 0);
    cycle(0, 0, 0, 1, 6, 32'h66, 1, 6, 6, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 6, 4);
    idle(2);

    // Reset in the middle of queued traffic: outputs must clear without a clock edge.
    cycle(1, 7, 32'h77, 1, 11, 32'h111, 1, 11, 0, 0);
    cycle(1, 12, 32'h12, 1, 13, 32'h113, 1, 13, 0, 0);
    @(negedge clk);
    set_idle();
    q_rs = 11;
    rst  = 1;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst = 0;

    // Randomized traffic; port A mostly honours a_stall.
    for (int i = 0; i < 400; i++) begin
      aw = ($urandom_range(0, 99) < 60);
      if (mdl_starve >= LIMIT && $urandom_range(0, 3) != 0) aw = 0;
      bv = ($urandom_range(0, 99) < 45);
      rv = ($urandom_range(0, 3) == 0);
      cycle(aw, 5'($urandom_range(0, 31)), $urandom, bv, 5'($urandom_range(0, 31)), $urandom,
            rv, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    idle(8);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
